life_engine: RTL and testbench

LIFE_ENGINE -- requirements
Module: life_engine

---
 rtl/life_engine_if.sv | 28 ++
 rtl/life_engine.sv | 141 ++++++++++++++
 tb/tb_life_engine.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/life_engine_if.sv
// Bus between the life engine and its double-buffered line store, plus the
// control/status signals seen by the host.
interface life_engine_if #(
  parameter int ADDR_SIZE  = 32,
  parameter int LINE_WIDTH = 8
);
  logic                  start_in;
  logic [ADDR_SIZE-1:0]  addr_logic_r;
  logic [LINE_WIDTH-1:0] data_logic_r;
  logic [ADDR_SIZE-1:0]  addr_logic_w;
  logic [LINE_WIDTH-1:0] data_logic_w;
  logic                  wr_en_out;
  logic                  swap_out;
  logic                  busy_out;
  logic [15:0]           gen_count_out;

  modport master (
    output start_in, data_logic_r,
    input  addr_logic_r, addr_logic_w, data_logic_w,
    input  wr_en_out, swap_out, busy_out, gen_count_out
  );

  modport slave (
    input  start_in, data_logic_r,
    output addr_logic_r, addr_logic_w, data_logic_w,
    output wr_en_out, swap_out, busy_out, gen_count_out
  );
endinterface

// File: rtl/life_engine.sv
// Computes one Game-of-Life generation on a toroidal board, streaming lines
// through a three-line window from the read buffer into the write buffer.
module life_engine #(
  parameter int ADDR_SIZE  = 32,
  parameter int LINE_WIDTH = 8,
  parameter int NUM_ROWS   = 8
) (
  input logic          clk_in,
  input logic          rst_in,
  life_engine_if.slave bus
);

  localparam logic [ADDR_SIZE-1:0] LAST_ROW = ADDR_SIZE'(NUM_ROWS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRIME0 = 3'd1,
    PRIME1 = 3'd2,
    PRIME2 = 3'd3,
    RUN    = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [ADDR_SIZE-1:0]  k_r;
  logic [ADDR_SIZE-1:0]  rd_addr_r;
  logic [ADDR_SIZE-1:0]  rd_addr_inc_s;
  logic [ADDR_SIZE-1:0]  wr_addr_hold_r;
  logic [LINE_WIDTH-1:0] top_r;
  logic [LINE_WIDTH-1:0] mid_r;
  logic [LINE_WIDTH-1:0] wr_data_hold_r;
  logic [LINE_WIDTH-1:0] next_line_s;
  logic [15:0]           gen_count_r;
  logic                  last_row_s;

  // Next state of one line from its upper, own and lower neighbours (both axes wrap).
  function automatic logic [LINE_WIDTH-1:0] life_next(
    input logic [LINE_WIDTH-1:0] top,
    input logic [LINE_WIDTH-1:0] mid,
    input logic [LINE_WIDTH-1:0] bot
  );
    logic [LINE_WIDTH-1:0] res;
    logic [3:0]            cnt;
    int                    l;
    int                    r;
    res = '0;
    for (int i = 0; i < LINE_WIDTH; i++) begin
      l = (i == 0) ? LINE_WIDTH - 1 : i - 1;
      r = (i == LINE_WIDTH - 1) ? 0 : i + 1;
      cnt = 4'(top[l]) + 4'(top[i]) + 4'(top[r]) +
            4'(mid[l]) + 4'(mid[r]) +
            4'(bot[l]) + 4'(bot[i]) + 4'(bot[r]);
      res[i] = (cnt == 4'd3) || (mid[i] && (cnt == 4'd2));
    end
    return res;
  endfunction

  assign last_row_s    = (k_r == LAST_ROW);
  assign rd_addr_inc_s = (rd_addr_r == LAST_ROW) ? '0 : rd_addr_r + ADDR_SIZE'(1);
  assign next_line_s   = life_next(top_r, mid_r, bus.data_logic_r);

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; start is only honoured while idle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (bus.start_in) state_s = PRIME0; else state_s = IDLE;
      PRIME0:  state_s = PRIME1;
      PRIME1:  state_s = PRIME2;
      PRIME2:  state_s = RUN;
      RUN:     if (last_row_s) state_s = DONE; else state_s = RUN;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Read pointer, line window, row counter, write hold registers and generation count.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      k_r            <= '0;
      rd_addr_r      <= '0;
      wr_addr_hold_r <= '0;
      wr_data_hold_r <= '0;
      top_r          <= '0;
      mid_r          <= '0;
      gen_count_r    <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start_in) rd_addr_r <= LAST_ROW;
          else              rd_addr_r <= rd_addr_r;
        end
        PRIME0: begin
          rd_addr_r <= rd_addr_inc_s;
        end
        PRIME1, PRIME2: begin
          rd_addr_r <= rd_addr_inc_s;
          top_r     <= mid_r;
          mid_r     <= bus.data_logic_r;
        end
        RUN: begin
          top_r          <= mid_r;
          mid_r          <= bus.data_logic_r;
          wr_addr_hold_r <= k_r;
          wr_data_hold_r <= next_line_s;
          // The row counter wraps by compare-and-reset so the next run starts at 0.
          if (last_row_s) begin
            k_r <= '0;
          end else begin
            k_r       <= k_r + ADDR_SIZE'(1);
            rd_addr_r <= rd_addr_inc_s;
          end
        end
        DONE: begin
          gen_count_r <= gen_count_r + 16'd1;
        end
        default: begin
          k_r <= '0;
        end
      endcase
    end
  end

  assign bus.addr_logic_r  = rd_addr_r;
  assign bus.addr_logic_w  = (state_r == RUN) ? k_r : wr_addr_hold_r;
  assign bus.data_logic_w  = (state_r == RUN) ? next_line_s : wr_data_hold_r;
  assign bus.wr_en_out     = (state_r == RUN);
  assign bus.swap_out      = (state_r == DONE);
  assign bus.busy_out      = (state_r != IDLE);
  assign bus.gen_count_out = gen_count_r;

endmodule

// File: tb/tb_life_engine.sv
// Directed bench for life_engine: models the double buffer and checks written
// lines and cycle-level control timing against hand-computed boards.
module tb_life_engine;
  localparam int AW = 32;
  localparam int W  = 8;
  localparam int N  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  life_engine_if #(.ADDR_SIZE(AW), .LINE_WIDTH(W)) bus ();

  life_engine #(.ADDR_SIZE(AW), .LINE_WIDTH(W), .NUM_ROWS(N)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  logic [W-1:0] rd_mem   [N];
  logic [W-1:0] wr_mem   [N];
  logic [W-1:0] load_val [N];
  logic         do_load = 1'b0;

  // Double-buffer model: registered read, write on wr_en, copy on swap.
  always @(posedge clk) begin
    bus.data_logic_r <= rd_mem[bus.addr_logic_r[2:0]];
    if (bus.wr_en_out) wr_mem[bus.addr_logic_w[2:0]] <= bus.data_logic_w;
    if (do_load) begin
      for (int r = 0; r < N; r++) rd_mem[r] <= load_val[r];
    end else if (bus.swap_out) begin
      for (int r = 0; r < N; r++) rd_mem[r] <= wr_mem[r];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic        tr_wr   [64];
  logic        tr_sw   [64];
  logic        tr_busy [64];
  logic [31:0] tr_aw   [64];
  logic [31:0] tr_ar   [64];
  logic [7:0]  tr_dw   [64];
  logic [15:0] tr_gen  [64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives cycles 0..ncyc-1 and records what the DUT shows in cycles 1..ncyc.
  task automatic run_trace(input int ncyc, input logic [63:0] start_mask, input int rst_cyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      bus.start_in = start_mask[c];
      rst          = (c == rst_cyc);
      @(posedge clk);
      #1;
      tr_wr[c+1]   = bus.wr_en_out;
      tr_sw[c+1]   = bus.swap_out;
      tr_busy[c+1] = bus.busy_out;
      tr_aw[c+1]   = bus.addr_logic_w;
      tr_ar[c+1]   = bus.addr_logic_r;
      tr_dw[c+1]   = bus.data_logic_w;
      tr_gen[c+1]  = bus.gen_count_out;
    end
    @(negedge clk);
    bus.start_in = 1'b0;
    rst          = 1'b0;
  endtask

  task automatic load_board(input logic [63:0] b);
    @(negedge clk);
    for (int r = 0; r < N; r++) load_val[r] = b[r*8 +: 8];
    do_load = 1'b1;
    @(negedge clk);
    do_load = 1'b0;
  endtask

  task automatic check_board(input string tag, input logic [63:0] exp);
    for (int r = 0; r < N; r++)
      check($sformatf("%s_row%0d", tag, r), 32'(wr_mem[r]), 32'(exp[r*8 +: 8]));
  endtask

  function automatic int count_swaps(input int ncyc);
    int s = 0;
    for (int c = 1; c <= ncyc; c++) if (tr_sw[c]) s++;
    return s;
  endfunction

  initial begin
    int nz;
    int nw;
    rst          = 1'b1;
    bus.start_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",  32'(bus.busy_out),      32'd0);
    check("rst_swap",  32'(bus.swap_out),      32'd0);
    check("rst_wr_en", 32'(bus.wr_en_out),     32'd0);
    check("rst_gen",   32'(bus.gen_count_out), 32'd0);
    check("rst_addr_r", bus.addr_logic_r,      32'd0);
    check("rst_addr_w", bus.addr_logic_w,      32'd0);
    check("rst_data_w", 32'(bus.data_logic_w), 32'd0);
    rst = 1'b0;

    // Vertical blinker turns horizontal.
    load_board(64'h00_00_08_08_08_00_00_00);
    run_trace(14, 64'h1, -1);
    check_board("blinker", 64'h00_00_00_1C_00_00_00_00);
    check("blinker_swap12", 32'(tr_sw[12]), 32'd1);
    check("blinker_swaps",  32'(count_swaps(14)), 32'd1);
    check("blinker_gen",    32'(tr_gen[13]), 32'd1);
    check("blinker_busy1",  32'(tr_busy[1]),  32'd1);
    check("blinker_busy13", 32'(tr_busy[13]), 32'd0);

    // Block is a still life; also write timing and hold behaviour.
    load_board(64'h00_00_00_00_18_18_00_00);
    run_trace(14, 64'h1, -1);
    check_board("block", 64'h00_00_00_00_18_18_00_00);
    for (int c = 3; c <= 12; c++) begin
      check($sformatf("block_wr_en_c%0d", c), 32'(tr_wr[c]), (c >= 4 && c <= 11) ? 32'd1 : 32'd0);
      if (c >= 4 && c <= 11) check($sformatf("block_addr_w_c%0d", c), tr_aw[c], 32'(c - 4));
    end
    check("block_addr_w_hold12", tr_aw[12], 32'd7);
    check("block_addr_w_hold13", tr_aw[13], 32'd7);
    check("block_data_w_hold12", 32'(tr_dw[12]), 32'd0);
    check("block_gen", 32'(tr_gen[13]), 32'd2);

    // Horizontal blinker wrapping across column 7/0 becomes vertical wrapping rows.
    load_board(64'h00_00_00_00_00_00_00_83);
    run_trace(14, 64'h1, -1);
    check_board("corner", 64'h01_00_00_00_00_00_01_01);

    // A start pulse during RUN must be ignored.
    load_board(64'h00_00_08_08_08_00_00_00);
    run_trace(16, 64'h41, -1);
    for (int c = 1; c <= 11; c++)
      check($sformatf("ignore_addr_r_c%0d", c), tr_ar[c], 32'((c + 6) % 8));
    check("ignore_swaps", 32'(count_swaps(16)), 32'd1);
    check("ignore_busy14", 32'(tr_busy[14]), 32'd0);
    check("ignore_gen", 32'(tr_gen[16]), 32'd4);

    // Reset in RUN k=3 aborts without a swap.
    run_trace(10, 64'h1, 7);
    check("abort_wr_en7", 32'(tr_wr[7]), 32'd1);
    check("abort_addr_w7", tr_aw[7], 32'd3);
    check("abort_gen7", 32'(tr_gen[7]), 32'd4);
    check("abort_wr_en8", 32'(tr_wr[8]), 32'd0);
    check("abort_busy8", 32'(tr_busy[8]), 32'd0);
    check("abort_addr_r8", tr_ar[8], 32'd0);
    check("abort_addr_w8", tr_aw[8], 32'd0);
    check("abort_data_w8", 32'(tr_dw[8]), 32'd0);
    check("abort_gen8", 32'(tr_gen[8]), 32'd0);
    check("abort_swaps", 32'(count_swaps(10)), 32'd0);
    load_board(64'h00_00_08_08_08_00_00_00);
    run_trace(14, 64'h1, -1);
    check_board("after_abort", 64'h00_00_00_1C_00_00_00_00);
    check("after_abort_gen", 32'(tr_gen[13]), 32'd1);

    // Empty board with start held for three back-to-back generations.
    run_trace(2, 64'h0, 0);
    load_board(64'h0);
    run_trace(42, 64'h0000_007F_FFFF_FFFF, -1);
    nz = 0;
    nw = 0;
    for (int c = 1; c <= 42; c++) begin
      if (tr_wr[c]) nw++;
      if (tr_wr[c] && tr_dw[c] != 8'h00) nz++;
    end
    check("empty_swap12", 32'(tr_sw[12]), 32'd1);
    check("empty_swap25", 32'(tr_sw[25]), 32'd1);
    check("empty_swap38", 32'(tr_sw[38]), 32'd1);
    check("empty_swaps", 32'(count_swaps(42)), 32'd3);
    check("empty_writes", 32'(nw), 32'd24);
    check("empty_nonzero", 32'(nz), 32'd0);
    check("empty_gen", 32'(tr_gen[42]), 32'd3);
    check("empty_busy_end", 32'(tr_busy[42]), 32'd0);
    check_board("empty", 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
